mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the core's instruction-fetch port and data-memory port. It arbitrates requests and sequences one outstanding access at a time through a fixed-latency synchronous memory. It returns registered read data or write acknowledges, and raises per-port stall signals that freeze the corresponding pipeline stage. It sits between the core and a single memory array, so the separate instruction and main memory paths collapse onto one port.

Parameters:
ADDR_WIDTH, 16, address width of both ports and memory
DATA_WIDTH, 16, data width of both ports and memory
MEM_LATENCY, 1, cycles from the memory enable cycle until mem_rdata is valid; legal range 1..4

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held high with if_addr stable until if_valid
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  registered fetch data
if_valid  out  1  one-cycle pulse; if_rdata valid
if_stall  out  1  fetch stage must hold
dm_req  in  1  data request; held high with dm_addr, dm_we and dm_wdata stable until dm_valid
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  write data
dm_rdata  out  DATA_WIDTH  registered read data
dm_valid  out  1  one-cycle pulse; read data valid or write done
dm_stall  out  1  memory stage must hold
mem_en  out  1  memory access enable, one cycle per transaction
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after the mem_en cycle

Behaviour:
- Reset (rst_n low at a rising clk edge) sets state to IDLE, the counter to 0 and last_grant to IF. It clears if_valid, dm_valid, if_rdata and dm_rdata to 0. While in IDLE with no grant, mem_en, mem_we, mem_addr and mem_wdata all drive 0.
- FSM states: IDLE and WAIT.
- IDLE grant cycle T:
  - A port is eligible when its req is 1 and its own valid is 0 in that cycle. This masks the port that is being acknowledged.
  - If only one port is eligible, that port is granted.
  - If both are eligible, the port not equal to last_grant is granted (round-robin). The first conflict after reset therefore goes to DM.
  - In the grant cycle, mem_en=1 and mem_addr is the granted port's address. For a DM grant, mem_we=dm_we and mem_wdata=dm_wdata; for an IF grant, mem_we=0. These outputs are combinational from the state and grant.
  - At the grant edge: last_grant <= granted port, counter <= MEM_LATENCY, state -> WAIT.
- WAIT state:
  - mem_en=0 and mem_we=0 throughout.
  - The counter decrements each cycle. WAIT lasts exactly MEM_LATENCY cycles (T+1 .. T+MEM_LATENCY).
  - On the edge that ends the last WAIT cycle:
    - For a read, mem_rdata is captured into the owner's rdata register.
    - For a DM write, dm_rdata is left unchanged.
    - The owner's valid is set for the following cycle and the state returns to IDLE.
- Latency: valid is high in cycle T+MEM_LATENCY+1. Peak throughput is one access per MEM_LATENCY+1 cycles.
- A new grant may occur in the same cycle as a valid pulse, but only to the other port.
- if_stall = if_req & ~if_valid and dm_stall = dm_req & ~dm_valid. Both are combinational.
- Each valid is high for exactly one cycle. Each rdata register holds its value until the next read completion for that port.
- If a port drops its req before its valid, the transaction still completes and the valid pulse is still issued.
- Reset mid-WAIT aborts the access: no valid pulse is issued and the late mem_rdata is ignored. A write already issued to memory is not undone.
- Starvation bound: with both ports requesting continuously, grants strictly alternate. Wait from req to valid is at most 2*(MEM_LATENCY+1) cycles.
- Address and data paths are pass-through; no width conversion occurs.

Test Plan:
1. Reset: rst_n low for 2 cycles while if_req=dm_req=1 -> all valids and rdatas 0, mem_en=0, and no grant occurs in either cycle.
2. IF read, L=1, mem[0x0005]=0xA1B2, if_req at cycle 0 -> cycle 0: mem_en=1, mem_addr=0x0005, mem_we=0. Cycle 2: if_valid=1, if_rdata=0xA1B2. if_stall=1 in cycles 0–1 and 0 in cycle 2.
3. DM write 0x0100<-0x1234 then DM read 0x0100 -> write: mem_we=1 for one cycle with mem_wdata=0x1234, dm_valid in cycle 2, dm_rdata unchanged. Read: dm_rdata=0x1234.
4. First conflict after reset, both req at cycle 0 (IF addr 0x0002, DM read 0x0010) -> DM granted in cycle 0 with dm_valid in cycle 2; IF granted in cycle 2 with if_valid in cycle 4.
5. Both ports requesting continuously for 20 cycles, L=2 -> grant order DM, IF, DM, IF…. Each valid pulse spaced 3 cycles apart, and no port waits more than 6 cycles.
6. L=3, IF read granted at cycle 0, rst_n low in cycle 2 -> if_valid never pulses and the FSM is IDLE after reset. A subsequent dm read is served normally with dm_valid 4 cycles after its grant.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared memory port around the arbiter.
// The arbiter uses the slave view; the core and memory together use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_valid;
  logic                  dm_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, dm_rdata, dm_valid, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency synchronous memory between the fetch and data ports,
// one outstanding access at a time, round-robin on conflicts.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 1   // legal range 1..4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = 3;

  typedef enum logic { IDLE, WAIT } state_t;
  typedef enum logic { PORT_IF, PORT_DM } port_t;

  state_t                state, state_nxt;
  port_t                 last_grant, grant_port;
  logic                  grant;
  logic                  done;
  logic                  op_we;
  logic                  if_elig, dm_elig;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  if_valid_q, dm_valid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;
  logic                  mem_en_c, mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;

  // A port whose valid is up this cycle is masked so it cannot be regranted.
  assign if_elig = bus.if_req & ~if_valid_q;
  assign dm_elig = bus.dm_req & ~dm_valid_q;
  assign done    = (state == WAIT) && (cnt == CNT_W'(1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_nxt   = state;
    cnt_nxt     = cnt;
    grant       = 1'b0;
    grant_port  = last_grant;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      IDLE: begin
        // Grants are suppressed while reset is asserted.
        if (rst_n && (if_elig || dm_elig)) begin
          grant = 1'b1;
          if (if_elig && dm_elig)
            grant_port = (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
          else
            grant_port = dm_elig ? PORT_DM : PORT_IF;
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(MEM_LATENCY);
          mem_en_c  = 1'b1;
          if (grant_port == PORT_DM) begin
            mem_we_c    = bus.dm_we;
            mem_addr_c  = bus.dm_addr;
            mem_wdata_c = bus.dm_wdata;
          end else begin
            mem_addr_c  = bus.if_addr;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (done) state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= PORT_IF;
      op_we      <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if (grant) begin
        last_grant <= grant_port;
        op_we      <= (grant_port == PORT_DM) && bus.dm_we;
      end
      // last_grant doubles as the owner of the access in flight.
      if (done) begin
        if (last_grant == PORT_IF) begin
          if_valid_q <= 1'b1;
          if_rdata_q <= bus.mem_rdata;
        end else begin
          dm_valid_q <= 1'b1;
          if (!op_we) dm_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_valid  = if_valid_q;
  assign bus.dm_valid  = dm_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Three arbiters (memory latency 1, 2, 3) each with a behavioural memory; directed
// requests push expected responses, per-instance monitors pop and compare on valid.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int N  = 3;

  typedef struct packed {
    logic [15:0] data;
    logic [31:0] cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t exp_q [2*N][$];

  logic          if_req   [N];
  logic          dm_req   [N];
  logic          dm_we    [N];
  logic [AW-1:0] if_addr  [N];
  logic [AW-1:0] dm_addr  [N];
  logic [DW-1:0] dm_wdata [N];

  logic          if_valid  [N];
  logic          dm_valid  [N];
  logic          if_stall  [N];
  logic          dm_stall  [N];
  logic          mem_en    [N];
  logic          mem_we    [N];
  logic [AW-1:0] mem_addr  [N];
  logic [DW-1:0] mem_wdata [N];
  logic [DW-1:0] if_rdata  [N];
  logic [DW-1:0] dm_rdata  [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int q, input logic [15:0] d, input int at);
    exp_t e;
    e.data = d;
    e.cyc  = 32'(at);
    exp_q[q].push_back(e);
  endtask

  task automatic sb_pop(input int q, input logic [15:0] d, input string name);
    exp_t e;
    if (exp_q[q].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected valid got=%0h want=none at cycle %0d", name, d, cyc);
    end else begin
      e = exp_q[q].pop_front();
      check({name, "_data"}, 32'(d), 32'(e.data));
      check({name, "_cycle"}, 32'(cyc), e.cyc);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int LAT = g + 1;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LATENCY(LAT)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    logic [DW-1:0] mem  [512];
    logic [DW-1:0] pipe [LAT];

    initial begin
      for (int a = 0; a < 512; a++) mem[a] <= 16'(a) ^ 16'hC3C3;
      mem[5] <= 16'hA1B2;
    end

    always @(posedge clk) begin
      if (bus.mem_en) begin
        if (bus.mem_we) mem[bus.mem_addr[8:0]] <= bus.mem_wdata;
        pipe[0] <= mem[bus.mem_addr[8:0]];
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end

    assign bus.mem_rdata = pipe[LAT-1];
    assign bus.if_req    = if_req[g];
    assign bus.if_addr   = if_addr[g];
    assign bus.dm_req    = dm_req[g];
    assign bus.dm_we     = dm_we[g];
    assign bus.dm_addr   = dm_addr[g];
    assign bus.dm_wdata  = dm_wdata[g];

    assign if_valid[g]  = bus.if_valid;
    assign dm_valid[g]  = bus.dm_valid;
    assign if_stall[g]  = bus.if_stall;
    assign dm_stall[g]  = bus.dm_stall;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;
    assign if_rdata[g]  = bus.if_rdata;
    assign dm_rdata[g]  = bus.dm_rdata;

    always @(negedge clk) begin
      if (rst_n) begin
        if (bus.if_valid) sb_pop(2*g,     bus.if_rdata, $sformatf("i%0d_if", g));
        if (bus.dm_valid) sb_pop(2*g + 1, bus.dm_rdata, $sformatf("i%0d_dm", g));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the start of the cycle after the valid pulse.
  task automatic wait_valid(input int i, input bit dm);
    int n = 0;
    forever begin
      @(negedge clk);
      if ((dm ? dm_valid[i] : if_valid[i]) === 1'b1) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL timeout i%0d %s valid got=none want=pulse at cycle %0d",
                 i, dm ? "dm" : "if", cyc);
        break;
      end
    end
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    for (int i = 0; i < N; i++) begin
      if_req[i] = 1'b1; dm_req[i] = 1'b1; dm_we[i] = 1'b0;
      if_addr[i] = '0;  dm_addr[i] = '0;  dm_wdata[i] = '0;
    end

    // Reset held two cycles with both requests high: no grant, everything cleared.
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("rst_i%0d_mem_en", i),   32'(mem_en[i]),   32'd0);
        check($sformatf("rst_i%0d_if_valid", i), 32'(if_valid[i]), 32'd0);
        check($sformatf("rst_i%0d_dm_valid", i), 32'(dm_valid[i]), 32'd0);
        check($sformatf("rst_i%0d_if_rdata", i), 32'(if_rdata[i]), 32'd0);
        check($sformatf("rst_i%0d_dm_rdata", i), 32'(dm_rdata[i]), 32'd0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      if_req[i] = 1'b0; dm_req[i] = 1'b0;
    end
    tick();

    // First conflict after reset (L=1): DM first, IF two cycles later.
    tick();
    c = cyc;
    if_addr[0] = 16'h0002; dm_addr[0] = 16'h0010; dm_we[0] = 1'b0;
    if_req[0]  = 1'b1;     dm_req[0]  = 1'b1;
    push_exp(1, 16'hC3D3, c + 2);
    push_exp(0, 16'hC3C1, c + 4);
    @(negedge clk);
    check("conf_mem_en",   32'(mem_en[0]),   32'd1);
    check("conf_mem_addr", 32'(mem_addr[0]), 32'h0010);
    fork
      begin wait_valid(0, 1'b1); dm_req[0] = 1'b0; end
      begin wait_valid(0, 1'b0); if_req[0] = 1'b0; end
    join

    // Single fetch (L=1) with stall profile.
    repeat (2) tick();
    c = cyc;
    if_addr[0] = 16'h0005; if_req[0] = 1'b1;
    push_exp(0, 16'hA1B2, c + 2);
    @(negedge clk);
    check("if_mem_en",   32'(mem_en[0]),   32'd1);
    check("if_mem_addr", 32'(mem_addr[0]), 32'h0005);
    check("if_mem_we",   32'(mem_we[0]),   32'd0);
    check("if_stall_c0", 32'(if_stall[0]), 32'd1);
    @(negedge clk);
    check("if_stall_c1", 32'(if_stall[0]), 32'd1);
    check("if_wait_en",  32'(mem_en[0]),   32'd0);
    @(negedge clk);
    check("if_stall_c2", 32'(if_stall[0]), 32'd0);
    tick();
    if_req[0] = 1'b0;

    // DM write leaves dm_rdata alone, then the read returns the written word.
    repeat (2) tick();
    c = cyc;
    dm_addr[0] = 16'h0100; dm_wdata[0] = 16'h1234; dm_we[0] = 1'b1; dm_req[0] = 1'b1;
    push_exp(1, 16'hC3D3, c + 2);
    @(negedge clk);
    check("wr_mem_en",    32'(mem_en[0]),    32'd1);
    check("wr_mem_we",    32'(mem_we[0]),    32'd1);
    check("wr_mem_addr",  32'(mem_addr[0]),  32'h0100);
    check("wr_mem_wdata", 32'(mem_wdata[0]), 32'h1234);
    check("wr_dm_stall",  32'(dm_stall[0]),  32'd1);
    @(negedge clk);
    check("wr_we_one_cycle", 32'(mem_we[0]), 32'd0);
    wait_valid(0, 1'b1);
    dm_req[0] = 1'b0; dm_we[0] = 1'b0;
    tick();
    c = cyc;
    dm_req[0] = 1'b1;
    push_exp(1, 16'h1234, c + 2);
    wait_valid(0, 1'b1);
    dm_req[0] = 1'b0;

    // Continuous contention (L=2): strict alternation, valids 3 cycles apart.
    repeat (2) tick();
    c = cyc;
    dm_addr[1] = 16'h0020; if_addr[1] = 16'h0030; dm_we[1] = 1'b0;
    dm_req[1]  = 1'b1;     if_req[1]  = 1'b1;
    push_exp(3, 16'hC3E3, c + 3);
    push_exp(3, 16'hC3E2, c + 9);
    push_exp(3, 16'hC3E1, c + 15);
    push_exp(3, 16'hC3E0, c + 21);
    push_exp(2, 16'hC3F3, c + 6);
    push_exp(2, 16'hC3F2, c + 12);
    push_exp(2, 16'hC3F1, c + 18);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          wait_valid(1, 1'b1);
          if (k < 3) dm_addr[1] = 16'h0021 + 16'(k);
          else       dm_req[1]  = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_valid(1, 1'b0);
          if (k < 2) if_addr[1] = 16'h0031 + 16'(k);
          else       if_req[1]  = 1'b0;
        end
      end
    join

    // Reset in the middle of a fetch (L=3) aborts it; a DM read then runs normally.
    repeat (2) tick();
    c = cyc;
    if_addr[2] = 16'h0044; if_req[2] = 1'b1;
    @(negedge clk);
    check("abort_grant", 32'(mem_en[2]), 32'd1);
    repeat (2) tick();
    rst_n = 1'b0; if_req[2] = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_valid_%0d", k), 32'(if_valid[2]), 32'd0);
    end
    check("abort_if_rdata", 32'(if_rdata[2]), 32'd0);
    tick();
    c = cyc;
    dm_addr[2] = 16'h0040; dm_we[2] = 1'b0; dm_req[2] = 1'b1;
    push_exp(5, 16'hC383, c + 4);
    @(negedge clk);
    check("post_rst_mem_en",   32'(mem_en[2]),   32'd1);
    check("post_rst_mem_addr", 32'(mem_addr[2]), 32'h0040);
    wait_valid(2, 1'b1);
    dm_req[2] = 1'b0;

    repeat (3) tick();
    for (int q = 0; q < 2*N; q++)
      check($sformatf("leftover_q%0d", q), 32'(exp_q[q].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
